// File: rtl/fibo_pkg.sv
// Shared types and defaults for the Fibonacci job arbiter slice.
package fibo_pkg;

    localparam int NUM_REQ_DEF = 4;
    localparam int N_W_DEF     = 5;
    localparam int RES_W_DEF   = 28;
    localparam int ID_W        = $clog2(NUM_REQ_DEF);

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        START,
        WAIT,
        RESP
    } state_t;

endpackage

// File: rtl/fibo_job_arbiter_rr_arbiter.sv
// Round-robin priority picker: first asserted request at or after ptr wins.
module rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [IDX_W-1:0]   idx,
    output logic               any_grant
);

    // Scan the request vector starting at ptr, wrapping modulo NUM_REQ.
    always_comb begin : pick
        int unsigned j;
        j         = 0;
        grant     = '0;
        idx       = '0;
        any_grant = 1'b0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            j = (32'(ptr) + k) % 32'(NUM_REQ);
            if (!any_grant && req[j]) begin
                grant[j]  = 1'b1;
                idx       = IDX_W'(j);
                any_grant = 1'b1;
            end
        end
    end

endmodule

// File: rtl/fibo_job_arbiter.sv
// Shares one Fibonacci engine among NUM_REQ requesters, one job at a time.
module fibo_job_arbiter
    import fibo_pkg::*;
#(
    parameter int NUM_REQ     = NUM_REQ_DEF,
    parameter int N_W         = N_W_DEF,
    parameter int RES_W       = RES_W_DEF,
    parameter int TIMEOUT_CYC = 64
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [NUM_REQ-1:0]         req_valid,
    input  logic [NUM_REQ*N_W-1:0]     req_n,
    output logic [NUM_REQ-1:0]         req_ready,
    output logic                       rsp_valid,
    input  logic                       rsp_ready,
    output logic [$clog2(NUM_REQ)-1:0] rsp_id,
    output logic [RES_W-1:0]           rsp_data,
    output logic                       rsp_err,
    output logic                       eng_clear,
    output logic                       eng_start,
    output logic [N_W-1:0]             eng_n,
    input  logic                       eng_done,
    input  logic [RES_W-1:0]           eng_result
);

    localparam int IDX_W = $clog2(NUM_REQ);
    localparam int CNT_W = $clog2(TIMEOUT_CYC);

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic [IDX_W-1:0]   id_q, id_d;
    logic [N_W-1:0]     n_q, n_d;
    logic [RES_W-1:0]   data_q, data_d;
    logic               err_q, err_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    logic [NUM_REQ-1:0] grant;
    logic [IDX_W-1:0]   grant_idx;
    logic               any_grant;
    logic [N_W-1:0]     sel_n;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_rr (
        .req       (req_valid),
        .ptr       (rr_ptr_q),
        .grant     (grant),
        .idx       (grant_idx),
        .any_grant (any_grant)
    );

    assign sel_n = req_n[grant_idx*N_W +: N_W];

    assign rsp_id   = id_q;
    assign rsp_data = data_q;
    assign rsp_err  = err_q;
    assign eng_n    = n_q;

    // State and job context registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            rr_ptr_q <= '0;
            id_q     <= '0;
            n_q      <= '0;
            data_q   <= '0;
            err_q    <= 1'b0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            id_q     <= id_d;
            n_q      <= n_d;
            data_q   <= data_d;
            err_q    <= err_d;
            cnt_q    <= cnt_d;
        end
    end

    // Next-state, job context updates and strobe outputs.
    always_comb begin
        state_d   = state_q;
        rr_ptr_d  = rr_ptr_q;
        id_d      = id_q;
        n_d       = n_q;
        data_d    = data_q;
        err_d     = err_q;
        cnt_d     = cnt_q;
        req_ready = '0;
        rsp_valid = 1'b0;
        eng_clear = 1'b0;
        eng_start = 1'b0;

        case (state_q)
            IDLE: begin
                if (any_grant) begin
                    req_ready = grant;
                    id_d      = grant_idx;
                    n_d       = sel_n;
                    rr_ptr_d  = IDX_W'((32'(grant_idx) + 32'd1) % 32'(NUM_REQ));
                    if (sel_n == '0) begin
                        data_d  = '0;
                        err_d   = 1'b0;
                        state_d = RESP;
                    end else begin
                        state_d = CLEAR;
                    end
                end
            end
            CLEAR: begin
                eng_clear = 1'b1;
                state_d   = START;
            end
            START: begin
                eng_start = 1'b1;
                cnt_d     = '0;
                state_d   = WAIT;
            end
            WAIT: begin
                cnt_d = cnt_q + 1'b1;
                // cnt_q==0 marks the first WAIT cycle, where eng_done may still
                // be left over from the previous job; done beats the timeout.
                if ((cnt_q != '0) && eng_done) begin
                    data_d  = eng_result;
                    err_d   = 1'b0;
                    state_d = RESP;
                end else if (cnt_q == CNT_W'(TIMEOUT_CYC - 1)) begin
                    data_d  = '0;
                    err_d   = 1'b1;
                    state_d = RESP;
                end
            end
            RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Strobes stay quiet while reset is held, even if the old state decodes otherwise.
        if (reset) begin
            req_ready = '0;
            rsp_valid = 1'b0;
            eng_clear = 1'b0;
            eng_start = 1'b0;
        end
    end

endmodule

// File: tb/tb_fibo_job_arbiter.sv
// Directed self-checking bench for fibo_job_arbiter with a small engine model.
module tb_fibo_job_arbiter;

    localparam int NR = 4;
    localparam int NW = 5;
    localparam int RW = 28;
    localparam int TO = 64;

    logic              clk = 1'b0;
    logic              reset;
    logic [NR-1:0]     req_valid;
    logic [NR*NW-1:0]  req_n;
    logic [NR-1:0]     req_ready;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [1:0]        rsp_id;
    logic [RW-1:0]     rsp_data;
    logic              rsp_err;
    logic              eng_clear;
    logic              eng_start;
    logic [NW-1:0]     eng_n;
    logic              eng_done = 1'b0;
    logic [RW-1:0]     eng_result = '0;

    fibo_job_arbiter #(
        .NUM_REQ     (NR),
        .N_W         (NW),
        .RES_W       (RW),
        .TIMEOUT_CYC (TO)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_n      (req_n),
        .req_ready  (req_ready),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_id     (rsp_id),
        .rsp_data   (rsp_data),
        .rsp_err    (rsp_err),
        .eng_clear  (eng_clear),
        .eng_start  (eng_start),
        .eng_n      (eng_n),
        .eng_done   (eng_done),
        .eng_result (eng_result)
    );

    always #5 clk = ~clk;

    // Engine model: done rises eng_lat cycles after the start pulse; in stale
    // mode clear leaves done up and it only drops one cycle after start.
    int          eng_lat = 8;
    logic [RW-1:0] eng_val = '0;
    bit          eng_never = 1'b0;
    bit          eng_stale = 1'b0;
    bit          busy = 1'b0;
    bit          drop = 1'b0;
    int          ecnt = 0;

    always @(posedge clk) begin
        if (eng_clear && !eng_stale) eng_done <= 1'b0;
        if (eng_start) begin
            busy <= 1'b1;
            ecnt <= 1;
            drop <= 1'b1;
        end else begin
            if (drop) begin
                eng_done <= 1'b0;
                drop     <= 1'b0;
            end
            if (busy) begin
                ecnt <= ecnt + 1;
                if (ecnt == eng_lat - 1 && !eng_never) begin
                    eng_done   <= 1'b1;
                    eng_result <= eng_val;
                    busy       <= 1'b0;
                end
            end
        end
    end

    // Monitor: grants, engine strobes, response latency and transfers.
    typedef struct { int id; int data; int err; } rsp_t;
    int       cyc = 0;
    int       last_grant_cyc = 0;
    int       clr_n = 0;
    int       st_n = 0;
    int       grant_q[$];
    int       lat_q[$];
    rsp_t     rsp_q[$];
    bit       prev_valid = 1'b0;
    bit       onehot_bad = 1'b0;
    logic [NW-1:0] n_at_start = '0;

    function automatic int idx_of(input logic [NR-1:0] v);
        int r;
        r = -1;
        for (int i = 0; i < NR; i++) if (v[i] && r < 0) r = i;
        return r;
    endfunction

    always @(negedge clk) begin
        cyc = cyc + 1;
        if (req_ready != '0) begin
            grant_q.push_back(idx_of(req_ready));
            last_grant_cyc = cyc;
            if ($countones(req_ready) != 1) onehot_bad = 1'b1;
        end
        if (eng_clear) clr_n = clr_n + 1;
        if (eng_start) begin
            st_n = st_n + 1;
            n_at_start = eng_n;
        end
        if (rsp_valid && !prev_valid) lat_q.push_back(cyc - last_grant_cyc);
        prev_valid = rsp_valid;
        if (rsp_valid && rsp_ready)
            rsp_q.push_back('{int'(rsp_id), int'(rsp_data), int'(rsp_err)});
    end

    int n_checks = 0;
    int n_fail = 0;
    bit keep_all = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // One clock: requesters drop valid once they have seen req_ready.
    task automatic step();
        logic [NR-1:0] rr;
        @(negedge clk);
        rr = req_ready;
        @(posedge clk);
        #1;
        req_valid = req_valid & ~rr;
        if (keep_all) req_valid = (grant_q.size() >= 5) ? '0 : '1;
    endtask

    task automatic set_req(input int i, input logic [NW-1:0] n);
        req_n[i*NW +: NW] = n;
        req_valid[i] = 1'b1;
    endtask

    task automatic wait_rsp(input string tag, input int budget,
                            output int id, output int data, output int err, output int lat);
        int k;
        rsp_t r;
        k = 0;
        while (rsp_q.size() == 0 && k < budget) begin
            step();
            k++;
        end
        id = -1; data = -1; err = -1; lat = -1;
        if (rsp_q.size() == 0) begin
            check({tag, "_rsp_seen"}, rsp_q.size(), 1);
        end else begin
            r = rsp_q.pop_front();
            id = r.id; data = r.data; err = r.err;
            if (lat_q.size() > 0) lat = lat_q.pop_front();
        end
    endtask

    task automatic job(input string tag, input int i, input logic [NW-1:0] n,
                       input int exp_id, input int exp_data, input int exp_err, input int exp_lat);
        int id, data, err, lat;
        set_req(i, n);
        wait_rsp(tag, 300, id, data, err, lat);
        check({tag, "_id"}, id, exp_id);
        check({tag, "_data"}, data, exp_data);
        check({tag, "_err"}, err, exp_err);
        if (exp_lat >= 0) check({tag, "_lat"}, lat, exp_lat);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int id, data, err, lat, c0, s0, s_id, s_data, s_err, k;
        bit stable, rdy0;

        reset = 1'b1; req_valid = '0; req_n = '0; rsp_ready = 1'b1;
        repeat (3) step();

        // Reset state, with a request already pending.
        set_req(0, 5'd10);
        #1;
        check("rst_req_ready", req_ready, 0);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_eng_clear", eng_clear, 0);
        check("rst_eng_start", eng_start, 0);
        check("rst_rsp_data", rsp_data, 0);
        check("rst_rsp_err", rsp_err, 0);
        check("rst_rsp_id", rsp_id, 0);
        check("rst_eng_n", eng_n, 0);

        // Single job: n=10, engine answers 55 after 8 cycles.
        eng_lat = 8; eng_val = 55; c0 = clr_n; s0 = st_n;
        reset = 1'b0;
        wait_rsp("single", 100, id, data, err, lat);
        check("single_id", id, 0);
        check("single_data", data, 55);
        check("single_err", err, 0);
        check("single_lat", lat, 11);
        check("single_clears", clr_n - c0, 1);
        check("single_starts", st_n - s0, 1);
        check("single_eng_n", n_at_start, 10);

        // Fairness from rr_ptr=0 with all four requesters busy.
        reset = 1'b1; step(); reset = 1'b0;
        grant_q.delete();
        eng_lat = 3; eng_val = 5;
        for (int i = 0; i < NR; i++) req_n[i*NW +: NW] = 5'd5;
        req_valid = '1; keep_all = 1'b1;
        for (int i = 0; i < 5; i++) begin
            wait_rsp("fair", 100, id, data, err, lat);
            check("fair_rsp_id", id, i % NR);
            check("fair_rsp_data", data, 5);
        end
        keep_all = 1'b0; req_valid = '0;
        check("fair_grant_count", grant_q.size(), 5);
        for (int i = 0; i < 5 && i < grant_q.size(); i++) check("fair_grant", grant_q[i], i % NR);

        // Bypass: n=0 never touches the engine.
        c0 = clr_n; s0 = st_n;
        job("bypass", 2, 5'd0, 2, 0, 0, 1);
        check("bypass_clears", clr_n - c0, 0);
        check("bypass_starts", st_n - s0, 0);

        // Backpressure: response held for 20 cycles, no new grants meanwhile.
        rsp_ready = 1'b0; eng_lat = 4; eng_val = 13;
        set_req(3, 5'd7);
        k = 0;
        while (!rsp_valid && k < 50) begin step(); k++; end
        check("bp_valid", rsp_valid, 1);
        s_id = int'(rsp_id); s_data = int'(rsp_data); s_err = int'(rsp_err);
        check("bp_id", s_id, 3);
        check("bp_data", s_data, 13);
        set_req(0, 5'd3);
        stable = 1'b1; rdy0 = 1'b1;
        repeat (20) begin
            step();
            if (rsp_valid !== 1'b1 || int'(rsp_id) != s_id || int'(rsp_data) != s_data
                || int'(rsp_err) != s_err) stable = 1'b0;
            if (req_ready !== '0) rdy0 = 1'b0;
        end
        check("bp_stable", stable, 1);
        check("bp_req_ready_low", rdy0, 1);
        check("bp_no_xfer", rsp_q.size(), 0);
        eng_val = 2; eng_lat = 3;
        rsp_ready = 1'b1;
        step();
        check("bp_xfer_first", rsp_q.size(), 1);
        wait_rsp("bp", 10, id, data, err, lat);
        check("bp_xfer_id", id, 3);
        check("bp_lat", lat, 7);
        wait_rsp("after_bp", 100, id, data, err, lat);
        check("after_bp_id", id, 0);
        check("after_bp_data", data, 2);

        // Timeout, recovery, and the done-versus-expiry boundary.
        eng_never = 1'b1;
        job("timeout", 1, 5'd20, 1, 0, 1, 67);
        eng_never = 1'b0; eng_lat = 5; eng_val = 8;
        job("recover", 2, 5'd6, 2, 8, 0, 8);
        eng_lat = 64; eng_val = 99;
        job("done_at_expiry", 3, 5'd11, 3, 99, 0, 67);
        eng_lat = 65; eng_val = 77;
        job("done_after_expiry", 0, 5'd12, 0, 0, 1, 67);

        // Leftover done from the previous job must be ignored in the first WAIT cycle.
        eng_stale = 1'b1; eng_lat = 6; eng_val = 21;
        job("stale_done", 1, 5'd8, 1, 21, 0, 9);
        eng_stale = 1'b0;

        // Reset in the middle of WAIT: job dropped, pointer back to 0.
        eng_lat = 30; eng_val = 1; s0 = st_n;
        set_req(1, 5'd4);
        k = 0;
        while (st_n == s0 && k < 20) begin step(); k++; end
        check("mr_started", st_n - s0, 1);
        repeat (3) step();
        set_req(0, 5'd9); set_req(2, 5'd9); set_req(3, 5'd9);
        reset = 1'b1;
        step();
        check("mr_req_ready", req_ready, 0);
        check("mr_rsp_valid", rsp_valid, 0);
        check("mr_eng_clear", eng_clear, 0);
        check("mr_eng_start", eng_start, 0);
        check("mr_rsp_data", rsp_data, 0);
        check("mr_rsp_err", rsp_err, 0);
        check("mr_rsp_id", rsp_id, 0);
        check("mr_eng_n", eng_n, 0);
        reset = 1'b0;
        #1;
        check("mr_first_grant", req_ready, 4'b0001);
        check("mr_no_stale", rsp_q.size(), 0);
        eng_lat = 3; eng_val = 34;
        wait_rsp("mr0", 100, id, data, err, lat);
        check("mr0_id", id, 0);
        check("mr0_data", data, 34);
        wait_rsp("mr1", 100, id, data, err, lat);
        check("mr1_id", id, 2);
        wait_rsp("mr2", 100, id, data, err, lat);
        check("mr2_id", id, 3);

        check("onehot_grants", onehot_bad, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
